ps2_event_controller: RTL and testbench
=======================================

Name: ps2_event_controller

Overview:
- Sequences the PS/2 receiver and turns its raw per-frame strobes into complete key events for the system side.
- Brings the receiver strobes and the raw PS/2 clock into the system clock domain.
- Merges the E0 and F0 prefixes with the following scan code and buffers finished events in a first-word-fall-through FIFO with a valid/ready handshake.
- Resets the receiver on a stalled frame or a keyboard self-test, and reports error status.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two, at least 2.
- FIFO_AW, 3: log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 50000: clk cycles of PS/2 clock inactivity mid-frame before recovery.
- TO_WIDTH, 16: width of the timeout counter; must be able to hold TIMEOUT_CYCLES.
- RST_CYCLES, 4: clk cycles rx_rst is held high during recovery.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock, monitored only.
- rx_data  in  11  receiver shift register: [9] start, [8:1] code bit-reversed ([8]=bit0, [1]=bit7), [0] parity.
- rx_data_latch  in  1  receiver strobe: ordinary code received.
- rx_release_key  in  1  receiver strobe: F0 received.
- rx_extended_code  in  1  receiver strobe: E0 received.
- rx_reset_required  in  1  receiver strobe: AA received.
- rx_rst  out  1  reset to receiver, active high.
- ev_data  out  10  FIFO head: [9] extended, [8] release, [7:0] scan code.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head this cycle.
- fifo_count  out  FIFO_AW+1  entries held.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- frame_err  out  1  sticky: timeout recovery occurred (also parity errors, see Optional Feature).
- kbd_reset_seen  out  1  one-cycle pulse when AA is received.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Flush the FIFO and clear all flags and counters.
  - ev_valid=0, fifo_count=0, overflow=0, frame_err=0, kbd_reset_seen=0.
  - rx_rst=1 during rst, then 0; state=IDLE.
- Synchronisation and sampling:
  - The four rx_* strobes and ps2_clk_in each pass through a 2-flop synchroniser, then a rising-edge detect (falling-edge detect for ps2_clk_in).
  - rx_data is captured in the cycle the strobe edge is detected; it is stable then because it only shifts on a PS/2 clock falling edge.
- Strobe priority when edges coincide: reset_required > data_latch > release_key > extended_code. Only the highest-priority strobe is acted on.
- State machine IDLE / PREFIX / PUSH / RECOVER:
  - IDLE: extended_code edge sets ext_pend and goes to PREFIX. release_key edge sets rel_pend and goes to PREFIX. data_latch edge goes to PUSH.
  - PREFIX: further prefix edges set their flag and stay in PREFIX. data_latch edge goes to PUSH.
  - PUSH (1 cycle): write {ext_pend, rel_pend, code}, where code[i]=rx_data[8-i]. Clear both flags and return to IDLE.
  - reset_required edge in any non-RECOVER state: clear both flags, pulse kbd_reset_seen, push nothing, go to IDLE.
  - RECOVER: hold rx_rst high for RST_CYCLES, clear both flags, set frame_err, then return to IDLE. Strobes are ignored while in RECOVER.
- Timeout:
  - Count PS/2 clock falling edges since the last strobe edge.
  - If that count is nonzero and TIMEOUT_CYCLES cycles pass with no PS/2 clock edge, enter RECOVER.
  - Any strobe edge clears both the edge count and the timer.
- Latency: strobe rising at the controller input to ev_valid=1 with an empty FIFO is exactly 4 clk cycles (2 synchroniser stages, 1 edge detect, 1 PUSH).
- FIFO:
  - Write on PUSH, read when ev_valid & ev_ready.
  - ev_data always shows the head entry; it is undefined when empty.
  - Full and push with no pop: drop the event, set overflow, count unchanged.
  - Full with push and pop in the same cycle: both take effect, count unchanged, overflow not set.
  - Empty with ev_ready=1: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags overflow and frame_err are cleared only by rst.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined:
  - At each strobe edge, check odd parity: XOR of rx_data[8:1] and rx_data[0] must equal 1.
  - On failure, discard the strobe, clear both flags, set frame_err and go to RECOVER.
- Not defined: parity is ignored; rx_data[0] is unused.

Test Plan:
- rx_data holding code 0x1C, data_latch pulse -> 4 cycles later ev_valid=1, ev_data=0x01C, fifo_count=1; ev_ready=1 for one cycle -> ev_valid=0.
- Strobe sequence extended, release, data_latch with code 0x75 -> a single event ev_data=0x375, both flags cleared afterwards.
- FIFO_DEPTH+1 data_latch events with ev_ready=0 -> fifo_count=FIFO_DEPTH, overflow=1, the first FIFO_DEPTH codes read back in order; then a simultaneous push and pop while full -> count unchanged, the new code present at the tail.
- Release strobe, then reset_required strobe -> kbd_reset_seen one cycle, no push; the next data_latch with 0x1C yields 0x01C, not 0x11C.
- 5 PS/2 clock falling edges, then idle for TIMEOUT_CYCLES -> rx_rst high for RST_CYCLES, frame_err=1, state IDLE; rst mid-RECOVER -> all outputs return to reset values.
- With PS2_PARITY_CHECK_EN defined: code 0x1C with rx_data[0]=1 (even total) -> no event, frame_err=1, rx_rst pulse; with rx_data[0]=0 -> event 0x01C.

Source files
------------

// File: rtl/ps2_event_controller.sv
// ps2_event_controller
//   Sequences a PS/2 receiver and turns its raw per-frame strobes into
//   complete key events. The strobes and the raw PS/2 clock are synchronised
//   into clk. E0/F0 prefixes are merged with the following scan code, and
//   finished events are buffered in a first-word-fall-through FIFO that has
//   a valid/ready handshake. A stalled frame (PS/2 clock stops mid-frame) or a
//   bad parity (when enabled) pulses rx_rst to the receiver and sets frame_err.
//
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity check on every
//   strobe; a failing strobe is discarded and triggers recovery).
//
// Ports
//   clk                in   system clock
//   rst                in   synchronous active-high reset
//   ps2_clk_in         in   raw PS/2 clock (monitored for activity only)
//   rx_data[10:0]      in   receiver shift register; [8:1] = code bit-reversed,
//                           [0] = parity
//   rx_data_latch      in   strobe: ordinary scan code received
//   rx_release_key     in   strobe: F0 received
//   rx_extended_code   in   strobe: E0 received
//   rx_reset_required  in   strobe: AA (self-test passed) received
//   rx_rst             out  reset to the receiver
//   ev_data[9:0]       out  FIFO head {extended, release, code}
//   ev_valid           out  FIFO not empty
//   ev_ready           in   consumer takes the head this cycle
//   fifo_count         out  entries held
//   overflow           out  sticky: event dropped on a full FIFO
//   frame_err          out  sticky: recovery happened
//   kbd_reset_seen     out  one-cycle pulse per AA
module ps2_event_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16,
  parameter int RST_CYCLES     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk_in,
  input  logic [10:0]        rx_data,
  input  logic               rx_data_latch,
  input  logic               rx_release_key,
  input  logic               rx_extended_code,
  input  logic               rx_reset_required,
  output logic               rx_rst,
  output logic [9:0]         ev_data,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               frame_err,
  output logic               kbd_reset_seen
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]    CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]    CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]  PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFIX  = 2'd1,
    ST_PUSH    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Synchronisers and edge detectors.
  // Strobe vector index: 3 reset_required, 2 data_latch, 1 release_key,
  // 0 extended_code. The third stage only remembers the previous value.
  // ---------------------------------------------------------------------
  logic [3:0] strb_raw, strb_s1_q, strb_s2_q, strb_s3_q, strb_rise;
  logic       ps2_s1_q, ps2_s2_q, ps2_s3_q;
  logic       ps2_fall, ps2_edge;

  assign strb_raw = {rx_reset_required, rx_data_latch, rx_release_key, rx_extended_code};

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_s1_q <= '0;
      strb_s2_q <= '0;
      strb_s3_q <= '0;
      // PS/2 clock idles high; starting high avoids a false falling edge.
      ps2_s1_q  <= 1'b1;
      ps2_s2_q  <= 1'b1;
      ps2_s3_q  <= 1'b1;
    end else begin
      strb_s1_q <= strb_raw;
      strb_s2_q <= strb_s1_q;
      strb_s3_q <= strb_s2_q;
      ps2_s1_q  <= ps2_clk_in;
      ps2_s2_q  <= ps2_s1_q;
      ps2_s3_q  <= ps2_s2_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb_edge
      assign strb_rise[gi] = strb_s2_q[gi] & ~strb_s3_q[gi];
    end
  endgenerate

  assign ps2_fall = ps2_s3_q & ~ps2_s2_q;
  assign ps2_edge = ps2_s3_q ^ ps2_s2_q;

  // Only the highest-priority coincident strobe is acted on.
  logic any_edge, act_rr, act_dl, act_rk, act_ec;
  assign any_edge = |strb_rise;
  assign act_rr   = strb_rise[3];
  assign act_dl   = strb_rise[2] & ~strb_rise[3];
  assign act_rk   = strb_rise[1] & ~(|strb_rise[3:2]);
  assign act_ec   = strb_rise[0] & ~(|strb_rise[3:1]);

  // Scan code arrives LSB-first, so rx_data[8] holds bit 0.
  logic [7:0] code_rx;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_code_rev
      assign code_rx[gi] = rx_data[8-gi];
    end
  endgenerate

  logic parity_ok;
`ifdef PS2_PARITY_CHECK_EN
  // Odd parity over the eight data bits plus the parity bit.
  assign parity_ok = ^rx_data[8:0];
`else
  assign parity_ok = 1'b1;
`endif

  // Start/stop bits (and parity when unchecked) carry nothing we need.
  logic unused_rx_bits;
  assign unused_rx_bits = ^{rx_data[10:9], rx_data[0]};

  logic in_recover, strobe_ok, parity_bad, timeout_hit;
  assign in_recover = (state_q == ST_RECOVER);
  assign strobe_ok  = any_edge & ~in_recover & parity_ok;
  assign parity_bad = any_edge & ~in_recover & ~parity_ok;

  // ---------------------------------------------------------------------
  // Stall detection: falling edges seen since the last strobe, and cycles
  // since the last PS/2 clock transition.
  // ---------------------------------------------------------------------
  logic [3:0]          fall_cnt_q;
  logic [TO_WIDTH-1:0] timer_q;
  logic [RC_W-1:0]     rcv_cnt_q;

  assign timeout_hit = (fall_cnt_q != 4'd0) & (timer_q == TO_LAST) & ~ps2_edge;

  always_ff @(posedge clk) begin
    if (rst || any_edge || in_recover) begin
      fall_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      if (ps2_fall && fall_cnt_q != 4'hF)
        fall_cnt_q <= fall_cnt_q + 4'd1;
      if (ps2_edge)
        timer_q <= '0;
      else if (fall_cnt_q != 4'd0 && timer_q != TO_LAST)
        timer_q <= timer_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !in_recover)
      rcv_cnt_q <= '0;
    else
      rcv_cnt_q <= rcv_cnt_q + RC_W'(1);
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECOVER: begin
        if (rcv_cnt_q == RC_LAST) state_d = ST_IDLE;
      end
      default: begin
        // PUSH accepts a new strobe directly so back-to-back codes are kept.
        if (parity_bad)
          state_d = ST_RECOVER;
        else if (strobe_ok) begin
          if (act_rr)      state_d = ST_IDLE;
          else if (act_dl) state_d = ST_PUSH;
          else             state_d = ST_PREFIX;
        end else if (timeout_hit)
          state_d = ST_RECOVER;
        else if (state_q == ST_PUSH)
          state_d = ST_IDLE;
      end
    endcase
  end

  logic push_req;
  always_comb begin
    rx_rst   = rst | (state_q == ST_RECOVER);
    push_req = (state_q == ST_PUSH);
  end

  // Prefix flags: cleared by a push, set by a new prefix in the same cycle.
  logic ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  always_comb begin
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    if (state_q == ST_PUSH) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end
    if (in_recover || state_d == ST_RECOVER) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (strobe_ok) begin
      if (act_rr) begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end else if (act_rk) begin
        rel_pend_d = 1'b1;
      end else if (act_ec) begin
        ext_pend_d = 1'b1;
      end
    end
  end

  logic [7:0] code_q;
  logic       kbd_q, overflow_q, frame_err_q;
  logic       drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      code_q      <= '0;
      kbd_q       <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      if (strobe_ok && act_dl)
        code_q <= code_rx;
      kbd_q <= strobe_ok & act_rr;
      if (drop)
        overflow_q <= 1'b1;
      if (state_d == ST_RECOVER && !in_recover)
        frame_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO, fall-through head via combinational read.
  // ---------------------------------------------------------------------
  logic [9:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               pop, full, wr_en;

  assign full  = (count_q == CNT_FULL);
  assign pop   = (count_q != '0) & ev_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign wr_en = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)
      count_d = count_q + CNT_ONE;
    else if (!wr_en && pop)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= {ext_pend_q, rel_pend_q, code_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  assign ev_data        = mem_q[rd_ptr_q];
  assign ev_valid       = (count_q != '0);
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign frame_err      = frame_err_q;
  assign kbd_reset_seen = kbd_q;

endmodule

// File: tb/tb_ps2_event_controller.sv
// Randomised bench for ps2_event_controller with a queue-based reference
// model of the event stream (prefix merging, FIFO occupancy and drops).
module tb_ps2_event_controller;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 200;
  localparam int TOW   = 16;
  localparam int RSTC  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk_in = 1'b1;
  logic [10:0]   rx_data = '0;
  logic          rx_data_latch = 1'b0;
  logic          rx_release_key = 1'b0;
  logic          rx_extended_code = 1'b0;
  logic          rx_reset_required = 1'b0;
  logic          ev_ready = 1'b0;
  logic          rx_rst;
  logic [9:0]    ev_data;
  logic          ev_valid;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          frame_err;
  logic          kbd_reset_seen;

  ps2_event_controller #(
    .FIFO_DEPTH(DEPTH), .FIFO_AW(AW), .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(TOW), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .rx_data(rx_data),
    .rx_data_latch(rx_data_latch), .rx_release_key(rx_release_key),
    .rx_extended_code(rx_extended_code), .rx_reset_required(rx_reset_required),
    .rx_rst(rx_rst), .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
    .kbd_reset_seen(kbd_reset_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [9:0] mq[$];       // events held by the FIFO
  int         due_q[$];    // cycle at which a pending event is written
  logic [9:0] pev_q[$];    // the pending event itself
  bit         m_ext, m_rel, m_ovf, m_ferr;
  int         cyc = 0;
  int         kbd_hi = 0;
  int         exp_kbd = 0;
  int         rst_hi = 0;
  int         rdy_mode = 0;  // 0 never ready, 1 always ready, 2 random

  // One clock: starts and ends at a falling edge.
  task automatic tick();
    bit pop;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = ($urandom_range(0, 2) != 0);
    endcase
    check_eq("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
    pop = (mq.size() != 0) && ev_ready;
    if (pop) check_eq("ev_data", 32'(ev_data), 32'(mq[0]));
    if (kbd_reset_seen) kbd_hi++;
    if (rx_rst) rst_hi++;
    @(posedge clk);
    cyc++;
    if (pop) void'(mq.pop_front());
    while (due_q.size() != 0 && due_q[0] == cyc) begin
      logic [9:0] ev;
      void'(due_q.pop_front());
      ev = pev_q.pop_front();
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // mask: [3] reset_required [2] data_latch [1] release_key [0] extended_code
  task automatic strobe_on(input logic [3:0] mask, input logic [7:0] code, input bit bad_par);
    logic [10:0] d;
    d[10] = 1'b1;
    d[9]  = 1'b0;
    for (int i = 0; i < 8; i++) d[8-i] = code[i];
    d[0] = ~(^code) ^ bad_par;
    rx_data = d;
    {rx_reset_required, rx_data_latch, rx_release_key, rx_extended_code} = mask;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) begin
      m_ext = 0; m_rel = 0; m_ferr = 1;
      return;
    end
`endif
    if (mask[3]) begin
      m_ext = 0; m_rel = 0; exp_kbd++;
    end else if (mask[2]) begin
      due_q.push_back(cyc + 4);
      pev_q.push_back({m_ext, m_rel, code});
      m_ext = 0; m_rel = 0;
    end else if (mask[1]) begin
      m_rel = 1;
    end else if (mask[0]) begin
      m_ext = 1;
    end
  endtask

  task automatic strobe_off();
    {rx_reset_required, rx_data_latch, rx_release_key, rx_extended_code} = 4'b0000;
  endtask

  task automatic send(input logic [3:0] mask, input logic [7:0] code, input int gap);
    strobe_on(mask, code, 1'b0);
    tick(); tick();
    strobe_off();
    repeat (gap) tick();
  endtask

  task automatic drain();
    int guard = 0;
    rdy_mode = 1;
    while ((mq.size() != 0 || due_q.size() != 0) && guard < 300) begin
      tick();
      guard++;
    end
    check_eq("drain_done", 32'(mq.size() + due_q.size()), 32'd0);
    rdy_mode = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    strobe_off();
    ps2_clk_in = 1'b1;
    rdy_mode = 0;
    ev_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mq.delete(); due_q.delete(); pev_q.delete();
    m_ext = 0; m_rel = 0; m_ovf = 0; m_ferr = 0;
    check_eq("rst_rx_rst", 32'(rx_rst), 32'd1);
    check_eq("rst_ev_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_kbd", 32'(kbd_reset_seen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rx_rst_rel", 32'(rx_rst), 32'd0);
  endtask

  // Five PS/2 clock pulses; leaves the line high.
  task automatic ps2_pulses();
    for (int i = 0; i < 5; i++) begin
      ps2_clk_in = 1'b0; repeat (5) tick();
      ps2_clk_in = 1'b1; repeat (5) tick();
    end
  endtask

  // Waits for rx_rst after the last PS/2 transition; returns cycles waited.
  task automatic wait_rx_rst(output int waited);
    waited = 5;
    while (!rx_rst && waited < TO + 20) begin
      tick();
      waited++;
    end
  endtask

  initial begin
    int w, hi, k0;
    logic [7:0] codes[DEPTH+2];

    do_reset();

    // Single event and exact latency
    strobe_on(4'b0100, 8'h1C, 1'b0);
    tick(); tick();
    strobe_off();
    tick();
    check_eq("lat_early_valid", 32'(ev_valid), 32'd0);
    tick();
    check_eq("lat_valid", 32'(ev_valid), 32'd1);
    check_eq("lat_data", 32'(ev_data), 32'h01C);
    check_eq("lat_count", 32'(fifo_count), 32'd1);
    rdy_mode = 1; tick(); rdy_mode = 0;
    check_eq("pop_empty", 32'(ev_valid), 32'd0);
    repeat (3) tick();

    // E0 F0 75 merges into one event
    send(4'b0001, 8'hE0, 4);
    send(4'b0010, 8'hF0, 4);
    send(4'b0100, 8'h75, 4);
    check_eq("ext_rel_data", 32'(ev_data), 32'h375);
    check_eq("ext_rel_count", 32'(fifo_count), 32'd1);
    drain();
    send(4'b0100, 8'h75, 4);
    check_eq("flags_cleared", 32'(ev_data), 32'h075);
    drain();

    // Fill, simultaneous push/pop while full, then a dropped event
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) codes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < DEPTH; i++) send(4'b0100, codes[i], 3);
    check_eq("full_count", 32'(fifo_count), 32'(DEPTH));
    strobe_on(4'b0100, codes[DEPTH], 1'b0);
    tick(); tick();
    strobe_off();
    tick();
    rdy_mode = 1; tick(); rdy_mode = 0;
    check_eq("pushpop_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("pushpop_no_ovf", 32'(overflow), 32'd0);
    repeat (3) tick();
    send(4'b0100, codes[DEPTH+1], 4);
    check_eq("drop_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("drop_ovf", 32'(overflow), 32'd1);
    check_eq("drop_head", 32'(ev_data), 32'({2'b00, codes[1]}));
    drain();

    // Release then self-test: flags dropped, pulse, nothing pushed
    do_reset();
    k0 = kbd_hi;
    send(4'b0010, 8'hF0, 4);
    send(4'b1000, 8'hAA, 4);
    check_eq("aa_pulse", 32'(kbd_hi - k0), 32'd1);
    check_eq("aa_no_push", 32'(fifo_count), 32'd0);
    send(4'b0100, 8'h1C, 4);
    check_eq("aa_then_code", 32'(ev_data), 32'h01C);
    drain();

    // Stalled frame recovery (pending release must be dropped)
    send(4'b0010, 8'hF0, 4);
    ps2_pulses();
    wait_rx_rst(w);
    check_eq("to_not_early", 32'(w >= TO), 32'd1);
    check_eq("to_fired", 32'(rx_rst), 32'd1);
    hi = 1;
    while (rx_rst && hi < RSTC + 10) begin
      tick();
      if (rx_rst) hi++;
    end
    m_rel = 0; m_ext = 0; m_ferr = 1;
    check_eq("to_rst_len", 32'(hi), 32'(RSTC));
    check_eq("to_frame_err", 32'(frame_err), 32'd1);
    repeat (3) tick();
    send(4'b0100, 8'h1C, 4);
    check_eq("to_flags_cleared", 32'(ev_data), 32'h01C);
    drain();

    // Reset in the middle of recovery
    ps2_pulses();
    wait_rx_rst(w);
    check_eq("to2_fired", 32'(rx_rst), 32'd1);
    tick();
    do_reset();

`ifdef PS2_PARITY_CHECK_EN
    rst_hi = 0;
    strobe_on(4'b0100, 8'h1C, 1'b1);
    tick(); tick();
    strobe_off();
    repeat (12) tick();
    check_eq("par_no_event", 32'(fifo_count), 32'd0);
    check_eq("par_frame_err", 32'(frame_err), 32'd1);
    check_eq("par_rx_rst", 32'(rst_hi), 32'(RSTC));
    send(4'b0100, 8'h1C, 4);
    check_eq("par_good", 32'(ev_data), 32'h01C);
    drain();
`endif

    // Randomised traffic
    do_reset();
    kbd_hi = 0;
    exp_kbd = 0;
    for (int n = 0; n < 250; n++) begin
      int r;
      logic [3:0] mask;
      if (n % 40 == 0) rdy_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 8)       mask = 4'b1000;
      else if (r < 50) mask = 4'b0100;
      else if (r < 72) mask = 4'b0010;
      else if (r < 92) mask = 4'b0001;
      else             mask = 4'($urandom_range(1, 15));
      send(mask, 8'($urandom_range(0, 255)), $urandom_range(3, 6));
    end
    drain();
    repeat (3) tick();
    check_eq("rand_kbd_pulses", 32'(kbd_hi), 32'(exp_kbd));
    check_eq("rand_frame_err", 32'(frame_err), 32'(m_ferr));
    check_eq("rand_overflow", 32'(overflow), 32'(m_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
